// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data memory responder with fixed access latency
module dmem_responder #(
   parameter int ADDR_W  = 9,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] word_idx;
   logic              addr_err;
   logic              access;
   logic              mem_we;

   // Decode of the registered request address: word index plus the error conditions
   // (byte offset inside a word, or any address bit above the array).
   assign word_idx = addr_q[ADDR_W+1:2];
   assign addr_err = (addr_q[1:0] != 2'b00) | ((addr_q >> (ADDR_W + 2)) != 32'd0);

   // The access edge is the one leaving WAIT with an exhausted counter; a coinciding
   // reset suppresses the store.
   assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
   assign mem_we = access & write_q & ~addr_err & ~rst;

   // Next-state, request capture, response formation and handshake outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      req_ready    = 1'b0;
      busy         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = ~rst;
            busy      = req_valid;
            if (req_valid && !rst) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = addr_err;
               if (addr_err) begin
                  resp_rdata_d = 32'd0;
               end else if (write_q) begin
                  resp_rdata_d = wdata_q;
               end else begin
                  resp_rdata_d = mem[word_idx];
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and response registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         write_q      <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[word_idx] <= wdata_q;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

   logic        clk;
   logic        rst        [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_write  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];
   logic        busy       [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit checking = 0;

   // behavioural model state, one slot per instance
   bit          m_pend     [2];
   int          m_acc      [2];
   bit          m_w        [2];
   logic [31:0] m_a        [2];
   logic [31:0] m_d        [2];
   bit          m_rv       [2];
   logic [31:0] m_rdata    [2];
   bit          m_err      [2];
   int          m_acc_cnt  [2];
   int          m_resp_cnt [2];
   int          m_last_acc [2];
   logic [31:0] mm         [2][512];

   // observed DUT responses
   int          d_resp_cnt  [2];
   int          d_resp_cyc  [2];
   logic [31:0] d_last_rdata[2];
   logic        d_last_err  [2];

   // burst stimulus table
   bit          bw     [8];
   logic [31:0] ba     [8];
   logic [31:0] bd     [8];
   int          b_acc  [8];

   dmem_responder #(.ADDR_W(9), .LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
      .busy(busy[0])
   );

   dmem_responder #(.ADDR_W(9), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
      .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %0s inst=%0d cyc=%0d actual=0x%08h expected=0x%08h", name, inst, cyc, act, exp);
      end
   endtask

   // Reference model: a request accepted at edge k is served at edge k+L using the
   // memory contents of that moment; reset drops whatever is outstanding.
   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         bit          idle;
         bit          err;
         int          idx;
         idle = !m_pend[i] && !m_rv[i];
         if (rst[i]) begin
            m_pend[i]  = 0;
            m_rv[i]    = 0;
            m_rdata[i] = 32'd0;
            m_err[i]   = 0;
         end else begin
            m_rv[i] = 0;
            if (m_pend[i] && cyc == m_acc[i] + lat(i)) begin
               err = (m_a[i] % 4 != 0) || (m_a[i] >= 32'd2048);
               idx = int'(m_a[i] / 4) % 512;
               if (err) begin
                  m_rdata[i] = 32'd0;
               end else if (m_w[i]) begin
                  mm[i][idx] = m_d[i];
                  m_rdata[i] = m_d[i];
               end else begin
                  m_rdata[i] = mm[i][idx];
               end
               m_err[i]  = err;
               m_rv[i]   = 1;
               m_pend[i] = 0;
               m_resp_cnt[i]++;
            end else if (idle && req_valid[i]) begin
               m_pend[i] = 1;
               m_acc[i]  = cyc;
               m_w[i]    = req_write[i];
               m_a[i]    = req_addr[i];
               m_d[i]    = req_wdata[i];
               m_last_acc[i] = cyc;
               m_acc_cnt[i]++;
            end
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < 2; i++) begin
            bit idle;
            idle = !m_pend[i] && !m_rv[i];
            chk("req_ready", i, req_ready[i], idle && !rst[i]);
            chk("busy", i, busy[i], m_pend[i] || (idle && req_valid[i]));
            chk("resp_valid", i, resp_valid[i], m_rv[i]);
            chk("resp_rdata", i, resp_rdata[i], m_rdata[i]);
            chk("resp_err", i, resp_err[i], m_err[i]);
            if (resp_valid[i] === 1'b1) begin
               d_resp_cnt[i]++;
               d_resp_cyc[i]   = cyc;
               d_last_rdata[i] = resp_rdata[i];
               d_last_err[i]   = resp_err[i];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d, input int rst_after);
      int a0, r0, n;
      a0 = m_acc_cnt[i];
      r0 = m_resp_cnt[i];
      req_write[i] = w;
      req_addr[i]  = a;
      req_wdata[i] = d;
      req_valid[i] = 1'b1;
      n = 0;
      while (m_acc_cnt[i] == a0 && n < 50) begin
         tick();
         n++;
      end
      req_valid[i] = 1'b0;
      chk("accept_wait", i, 32'(n < 50), 32'd1);
      if (rst_after >= 0) begin
         repeat (rst_after) tick();
         rst[i] = 1'b1;
         tick();
         rst[i] = 1'b0;
      end else begin
         n = 0;
         while (m_resp_cnt[i] == r0 && n < 50) begin
            tick();
            n++;
         end
         chk("resp_wait", i, 32'(n < 50), 32'd1);
      end
      tick();
   endtask

   task automatic burst(input int i, input int n);
      int a0, r0, k, t;
      a0 = m_acc_cnt[i];
      r0 = m_resp_cnt[i];
      k  = 0;
      req_write[i] = bw[0];
      req_addr[i]  = ba[0];
      req_wdata[i] = bd[0];
      req_valid[i] = 1'b1;
      t = 0;
      while (k < n && t < 200) begin
         tick();
         t++;
         if (m_acc_cnt[i] != a0 + k) begin
            b_acc[k] = m_last_acc[i];
            k++;
            if (k < n) begin
               req_write[i] = bw[k];
               req_addr[i]  = ba[k];
               req_wdata[i] = bd[k];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid[i] = 1'b0;
      chk("burst_accept_wait", i, 32'(t < 200), 32'd1);
      t = 0;
      while (m_resp_cnt[i] < r0 + n && t < 50) begin
         tick();
         t++;
      end
      chk("burst_resp_wait", i, 32'(t < 50), 32'd1);
      tick();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom % 8)
         0, 1, 2, 3: a = 32'($urandom % 16) * 4;
         4:          a = 32'h0000_07FC - 32'($urandom % 4) * 4;
         5:          a = (32'($urandom % 16) * 4) | 32'($urandom_range(1, 3));
         6:          a = $urandom | 32'h0000_0800;
         default:    a = $urandom;
      endcase
      return a;
   endfunction

   initial begin
      int r0;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1;
         req_valid[i] = 1'b0;
         req_write[i] = 1'b0;
         req_addr[i]  = 32'd0;
         req_wdata[i] = 32'd0;
         m_pend[i] = 0; m_rv[i] = 0; m_rdata[i] = 32'd0; m_err[i] = 0;
         m_acc_cnt[i] = 0; m_resp_cnt[i] = 0; m_acc[i] = 0; m_last_acc[i] = 0;
         d_resp_cnt[i] = 0; d_resp_cyc[i] = 0; d_last_rdata[i] = 32'd0; d_last_err[i] = 1'b0;
         for (int j = 0; j < 512; j++) mm[i][j] = 32'd0;
      end
      repeat (3) tick();
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      checking = 1;
      tick();

      // store then load, latency 2
      do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, -1);
      chk("t1_store_rdata", 0, d_last_rdata[0], 32'hDEAD_BEEF);
      chk("t1_store_err", 0, 32'(d_last_err[0]), 32'd0);
      chk("t1_latency", 0, 32'(d_resp_cyc[0] - m_last_acc[0]), 32'd2);
      do_req(0, 1'b0, 32'h0000_0010, 32'd0, -1);
      chk("t1_load_rdata", 0, d_last_rdata[0], 32'hDEAD_BEEF);

      // misaligned store leaves the array alone
      do_req(0, 1'b1, 32'h0000_0013, 32'h1111_1111, -1);
      chk("t2_err", 0, 32'(d_last_err[0]), 32'd1);
      chk("t2_rdata", 0, d_last_rdata[0], 32'd0);
      do_req(0, 1'b0, 32'h0000_0010, 32'd0, -1);
      chk("t2_load_rdata", 0, d_last_rdata[0], 32'hDEAD_BEEF);

      // range boundary
      do_req(0, 1'b0, 32'h0000_0800, 32'd0, -1);
      chk("t3_oor_err", 0, 32'(d_last_err[0]), 32'd1);
      chk("t3_oor_rdata", 0, d_last_rdata[0], 32'd0);
      do_req(0, 1'b0, 32'h0000_07FC, 32'd0, -1);
      chk("t3_top_err", 0, 32'(d_last_err[0]), 32'd0);
      chk("t3_top_rdata", 0, d_last_rdata[0], 32'd0);

      // reset while waiting with one cycle left
      r0 = d_resp_cnt[0];
      do_req(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 0);
      chk("t4_no_resp", 0, 32'(d_resp_cnt[0] - r0), 32'd0);
      do_req(0, 1'b0, 32'h0000_0020, 32'd0, -1);
      chk("t4_load_rdata", 0, d_last_rdata[0], 32'd0);

      // held request, three loads
      r0 = d_resp_cnt[0];
      for (int k = 0; k < 3; k++) begin
         bw[k] = 1'b0;
         ba[k] = 32'(k * 4);
         bd[k] = 32'd0;
      end
      burst(0, 3);
      chk("t5_spacing_a", 0, 32'(b_acc[1] - b_acc[0]), 32'd4);
      chk("t5_spacing_b", 0, 32'(b_acc[2] - b_acc[1]), 32'd4);
      chk("t5_pulses", 0, 32'(d_resp_cnt[0] - r0), 32'd3);

      // latency 1: store then load back to back
      bw[0] = 1'b1; ba[0] = 32'h0000_0040; bd[0] = 32'hCAFE_F00D;
      bw[1] = 1'b0; ba[1] = 32'h0000_0040; bd[1] = 32'd0;
      burst(1, 2);
      chk("t6_spacing", 1, 32'(b_acc[1] - b_acc[0]), 32'd3);
      chk("t6_latency", 1, 32'(d_resp_cyc[1] - m_last_acc[1]), 32'd1);
      chk("t6_load_rdata", 1, d_last_rdata[1], 32'hCAFE_F00D);

      // randomized traffic on both builds
      for (int it = 0; it < 300; it++) begin
         int i;
         int sel;
         i   = $urandom % 2;
         sel = $urandom % 10;
         if (sel == 0) begin
            int n;
            n = $urandom_range(2, 3);
            for (int k = 0; k < n; k++) begin
               bw[k] = 1'($urandom % 2);
               ba[k] = rand_addr();
               bd[k] = $urandom;
            end
            burst(i, n);
         end else if (sel == 1) begin
            do_req(i, 1'($urandom % 2), rand_addr(), $urandom, $urandom_range(0, 3));
         end else begin
            do_req(i, 1'($urandom % 2), rand_addr(), $urandom, -1);
         end
         repeat ($urandom % 3) tick();
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
